spike_history: RTL and testbench
================================

# spike_history

Per-time-step spike history stage for a neuron block. On every `time_step` pulse it latches the block's spike vector into a T-deep shift history. That history is the block's `spike_in[T-1:0]` synapse input, which closes the recurrent loop. Each captured vector is also stamped with a time-step index and queued into a small FIFO. The FIFO is drained as an AXI-stream spike raster for monitoring and export.

## Interface
Parameters:
- `T`, 4: history depth in time steps; must be ≥ 1.
- `N`, 8: neurons per block, which is the spike vector width.
- `DEPTH`, 8: raster FIFO depth in records; power of two, ≥ 2.
- `TS_W`, 16: time-step counter width.

Ports:
- `aclk`, input, 1: clock; the single clock domain.
- `aresetn`, input, 1: reset; asynchronous and active-low.
- `spike`, input, N: current spike vector from the neuron block (its `spike_out`).
- `time_step`, input, 1: single-cycle pulse marking the end of a time step.
- `spike_hist`, output, N×T (unpacked `[T-1:0]`): `spike_hist[0]` is the newest vector, `spike_hist[T-1]` the oldest.
- `step_count`, output, TS_W: number of `time_step` pulses since reset, modulo 2^TS_W.
- `m_tdata`, output, TS_W+N: raster record `{step, spikes}`.
- `m_tvalid`, output, 1: record valid.
- `m_tready`, input, 1: downstream ready.
- `overflow`, output, 1: sticky flag, set when a record was dropped.
- `drop_count`, output, 8: number of dropped records, saturating at 255.

## Operation
- Reset values: `spike_hist` all 0, `step_count` 0, FIFO empty, `m_tvalid` 0, `m_tdata` 0, `overflow` 0, `drop_count` 0.
- On an edge with `time_step`=1:
  - `spike_hist[0]` ← `spike`.
  - `spike_hist[k]` ← `spike_hist[k-1]` for k = 1..T-1.
  - `step_count` ← `step_count` + 1, wrapping from 2^TS_W−1 to 0.
  - A record `{step_count (pre-increment value), spike}` is pushed to the FIFO.
- Without a `time_step` pulse, all history and counter state holds.
- FIFO full at a push edge with no pop on that edge:
  - The record is dropped and FIFO contents are unchanged.
  - `overflow` ← 1.
  - `drop_count` increments, saturating at 255.
- FIFO full with push and pop on the same edge: the pop frees a slot, the push is accepted, and nothing is dropped.
- A pop occurs on an edge where `m_tvalid`=1 and `m_tready`=1.
- Once `m_tvalid` is asserted, `m_tdata` and `m_tvalid` stay stable until the pop.
- `m_tvalid` does not depend combinationally on `m_tready`.
- `overflow` and `drop_count` clear only on reset.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for a clock edge, and queued records are discarded.

## Timing
- History latency: `spike_hist` and `step_count` show the new values the cycle after the `time_step` edge.
- Stream latency: the FIFO is registered. A record pushed at edge E can first appear with `m_tvalid`=1 after edge E, i.e. in the cycle following E.
- Throughput: one pop per cycle while the FIFO is non-empty and `m_tready`=1.
- Consecutive-cycle `time_step` pulses are legal. Each pulse shifts the history and pushes one record.

## Configuration
- Macro: `SPIKE_HISTORY_SKIP_ZERO_EN`.
- When defined:
  - Edges where `spike` is all zero push no record and cannot cause a drop.
  - History still shifts and `step_count` still increments, so gaps in `step` values mark silent steps.
- When undefined: every `time_step` pulse pushes a record, including all-zero vectors.

## Structure
- Shared package `snn_pkg` holds:
  - typedef `spike_rec_t`, a packed struct `{logic [TS_W-1:0] step; logic [N-1:0] spikes;}`, parameterised via the package's width constants;
  - constant `SPIKE_DROP_CNT_W = 8`.
- One sub-module, `spike_fifo`: a synchronous first-word-registered FIFO with parameters `WIDTH` and `DEPTH`, plus ports `full`/`empty`, push, and pop/valid.
- History register, step counter, and drop logic live in `spike_history` itself.

## Test plan
All scenarios use N=4, T=3, DEPTH=4, TS_W=16.
- Reset then three pulses with spike = 4'h1, 4'h2, 4'h4 → `spike_hist` = {4'h1, 4'h2, 4'h4} ([2]..[0]); `step_count` = 3; records drained in order {0,1}, {1,2}, {2,4}.
- Backpressure: hold `m_tready`=0 and apply 6 pulses → exactly 4 records are held, `overflow`=1, `drop_count`=2; releasing `m_tready` drains steps 0..3.
- Full with simultaneous pop and push: FIFO full, `m_tready`=1 on the same edge as `time_step` → no drop and the FIFO stays at 4 entries.
- Counter wrap: preload with 65535 pulses, then apply one more → record step = 65535 and `step_count` = 0.
- `SPIKE_HISTORY_SKIP_ZERO_EN` defined, spike sequence 4'h3, 4'h0, 4'h8 → records {0,3} and {2,8} only; history = {4'h3, 4'h0, 4'h8}.
- Assert `aresetn` low mid-stream with `m_tvalid`=1 → `m_tvalid` falls immediately, history, counters and flags read 0, and the next record after reset has step 0.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and constants for the spike-history datapath.
package snn_pkg;

  localparam int SNN_N            = 8;
  localparam int SNN_TS_W         = 16;
  localparam int SPIKE_DROP_CNT_W = 8;

  // The record layout {step, spikes}. Blocks with non-default widths build the same layout by concatenation.
  typedef struct packed {
    logic [SNN_TS_W-1:0] step;
    logic [SNN_N-1:0]    spikes;
  } spike_rec_t;

  function automatic logic [SPIKE_DROP_CNT_W-1:0] sat_inc(
    input logic [SPIKE_DROP_CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/spike_fifo.sv
// Synchronous first-word-fall-through FIFO: the head record is visible on rdata whenever valid is high.
module spike_fifo
  import snn_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign valid   = ~empty;
  assign do_pop  = pop & ~empty;
  // When full, a push is only taken if the head leaves on the same edge.
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage has no reset; stale words are never observable because rdata is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/spike_history.sv
// Per-time-step spike history shift register, step counter and raster stream export.
// Build option SPIKE_HISTORY_SKIP_ZERO_EN: all-zero spike vectors push no raster record.
module spike_history
  import snn_pkg::*;
#(
  parameter int T     = 4,
  parameter int N     = 8,
  parameter int DEPTH = 8,
  parameter int TS_W  = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [N-1:0]                spike,
  input  logic                        time_step,
  output logic [N-1:0]                spike_hist [T-1:0],
  output logic [TS_W-1:0]             step_count,
  output logic [TS_W+N-1:0]           m_tdata,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic                        overflow,
  output logic [SPIKE_DROP_CNT_W-1:0] drop_count
);

  logic [N-1:0]                hist_q [T-1:0];
  logic [TS_W-1:0]             step_q;
  logic                        overflow_q;
  logic [SPIKE_DROP_CNT_W-1:0] drop_q;

  logic push_req, fifo_push, fifo_pop, fifo_full, fifo_empty, drop;

`ifdef SPIKE_HISTORY_SKIP_ZERO_EN
  assign push_req = time_step & (|spike);
`else
  assign push_req = time_step;
`endif

  assign fifo_pop  = m_tready & ~fifo_empty;
  assign drop      = push_req & fifo_full & ~fifo_pop;
  assign fifo_push = push_req & ~drop;

  spike_fifo #(
    .WIDTH (TS_W + N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (aclk),
    .rst_n (aresetn),
    .push  (fifo_push),
    .wdata ({step_q, spike}),
    .pop   (m_tready),
    .rdata (m_tdata),
    .valid (m_tvalid),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // NOTE: non-blocking assignments let every stage sample the previous stage's old value on the same edge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int k = 0; k < T; k++) hist_q[k] <= '0;
      step_q <= '0;
    end else if (time_step) begin
      hist_q[0] <= spike;
      for (int k = 1; k < T; k++) hist_q[k] <= hist_q[k-1];
      step_q <= step_q + 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      drop_q     <= sat_inc(drop_q);
    end
  end

  assign spike_hist = hist_q;
  assign step_count = step_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_spike_history.sv
// Scoreboard bench for spike_history (N=4, T=3, DEPTH=4, TS_W=16) with a queue-level reference model.
`timescale 1ns/1ps
module tb_spike_history;

  localparam int T = 3, N = 4, DEPTH = 4, TS_W = 16;

  logic            clk = 1'b0;
  logic            aresetn;
  logic [N-1:0]    spike;
  logic            time_step;
  logic            tready;
  logic [N-1:0]    spike_hist [T-1:0];
  logic [TS_W-1:0] step_count;
  logic [TS_W+N-1:0] m_tdata;
  logic            m_tvalid;
  logic            overflow;
  logic [7:0]      drop_count;

  spike_history #(.T(T), .N(N), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .aclk       (clk),
    .aresetn    (aresetn),
    .spike      (spike),
    .time_step  (time_step),
    .spike_hist (spike_hist),
    .step_count (step_count),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (tready),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [TS_W+N-1:0] sb [$];
  logic [N-1:0]      m_hist [$];
  int                occ;
  logic [TS_W-1:0]   m_step;
  bit                m_ovf;
  int                m_drops;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    sb.delete();
    m_hist = '{'0, '0, '0};
    occ = 0; m_step = '0; m_ovf = 1'b0; m_drops = 0;
  endtask

  // Apply one cycle of stimulus, advance the model over the edge, return at posedge+2.
  task automatic cycle(input bit ts, input logic [N-1:0] sp, input bit rd);
    bit pop, push_req;
    time_step = ts; spike = sp; tready = rd;
    @(posedge clk);
    pop = (occ > 0) && rd;
    push_req = ts;
`ifdef SPIKE_HISTORY_SKIP_ZERO_EN
    push_req = ts && (sp != '0);
`endif
    if (push_req) begin
      if (occ < DEPTH || pop) begin
        sb.push_back({m_step, sp});
        occ++;
      end else begin
        m_ovf = 1'b1;
        if (m_drops < 255) m_drops++;
      end
    end
    if (pop) occ--;
    if (ts) begin
      m_hist.push_front(sp);
      void'(m_hist.pop_back());
      m_step = m_step + 1'b1;
    end
    #2;
  endtask

  task automatic do_reset();
    time_step = 1'b0; tready = 1'b0;
    aresetn = 1'b0;
    #1;
    model_reset();
    @(posedge clk); #2;
    aresetn = 1'b1;
  endtask

  // Monitor: compare DUT against the model away from the active edge.
  always @(negedge clk) begin
    if (aresetn) begin
      check("tvalid", m_tvalid, occ > 0);
      if (m_tvalid && tready) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL sb_underflow: got record %0h expected none", m_tdata);
        end else begin
          check("tdata", m_tdata, sb.pop_front());
        end
      end
      for (int k = 0; k < T; k++) check($sformatf("hist%0d", k), spike_hist[k], m_hist[k]);
      check("step_count", step_count, m_step);
      check("overflow", overflow, m_ovf);
      check("drop_count", drop_count, m_drops);
    end
  end

  initial begin
    aresetn = 1'b0; time_step = 1'b0; spike = '0; tready = 1'b0;
    model_reset();
    #1;
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_step", step_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_drops", drop_count, 0);
    for (int k = 0; k < T; k++) check("rst_hist", spike_hist[k], 0);
    @(posedge clk); @(posedge clk); #2;
    aresetn = 1'b1;

    // Basic capture and in-order drain
    cycle(1, 4'h1, 0); cycle(1, 4'h2, 0); cycle(1, 4'h4, 0);
    check("basic_hist2", spike_hist[2], 4'h1);
    check("basic_hist1", spike_hist[1], 4'h2);
    check("basic_hist0", spike_hist[0], 4'h4);
    check("basic_step", step_count, 3);
    check("basic_head", m_tdata, {16'd0, 4'h1});
    repeat (5) cycle(0, 4'h0, 1);
    check("basic_drained", m_tvalid, 0);

    // Backpressure overflow, then full with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1, 4'(i + 1), 0);
    check("bp_overflow", overflow, 1);
    check("bp_drops", drop_count, 2);
    check("bp_head", m_tdata, {16'd0, 4'h1});
    cycle(1, 4'h9, 1);
    check("full_pushpop_drops", drop_count, 2);
    check("full_pushpop_head", m_tdata, {16'd1, 4'h2});
    cycle(1, 4'hA, 0);
    check("still_full_drops", drop_count, 3);
    repeat (6) cycle(0, 4'h0, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 2) != 0));
    repeat (6) cycle(0, 4'h0, 1);

    // Step counter wrap
    do_reset();
    for (int i = 0; i < 65535; i++) cycle(1, 4'($urandom), 1'($urandom_range(0, 1)));
    repeat (6) cycle(0, 4'h0, 1);
    check("wrap_pre", step_count, 16'hFFFF);
    cycle(1, 4'h5, 0);
    check("wrap_step", step_count, 0);
    check("wrap_rec", m_tdata, {16'hFFFF, 4'h5});
    check("wrap_drops_sat", drop_count, m_drops);
    repeat (3) cycle(0, 4'h0, 1);

    // Silent step handling
    do_reset();
    cycle(1, 4'h3, 0); cycle(1, 4'h0, 0); cycle(1, 4'h8, 0);
    check("sz_hist2", spike_hist[2], 4'h3);
    check("sz_hist1", spike_hist[1], 4'h0);
    check("sz_hist0", spike_hist[0], 4'h8);
`ifdef SPIKE_HISTORY_SKIP_ZERO_EN
    cycle(0, 4'h0, 1);
    check("sz_second", m_tdata, {16'd2, 4'h8});
`else
    cycle(0, 4'h0, 1);
    check("sz_second", m_tdata, {16'd1, 4'h0});
`endif
    repeat (5) cycle(0, 4'h0, 1);

    // Reset mid-stream with a record pending
    cycle(1, 4'hC, 0); cycle(1, 4'hD, 0);
    check("mid_valid", m_tvalid, 1);
    time_step = 1'b0;
    aresetn = 1'b0;
    #1;
    check("mid_rst_tvalid", m_tvalid, 0);
    check("mid_rst_tdata", m_tdata, 0);
    check("mid_rst_step", step_count, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_drops", drop_count, 0);
    for (int k = 0; k < T; k++) check("mid_rst_hist", spike_hist[k], 0);
    model_reset();
    @(posedge clk); #2;
    aresetn = 1'b1;
    cycle(1, 4'h7, 1);
    check("post_rst_rec", m_tdata, {16'd0, 4'h7});
    repeat (3) cycle(0, 4'h0, 1);
    check("end_empty", m_tvalid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
